// File: rtl/regfile_access_master_if.sv
// Bundle of the command, response and register-file strobe signals used by
// regfile_access_master. The master modport is the access block's view; the
// slave modport is the view of whatever drives commands and models the
// register file.
interface regfile_access_master_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic              rf_wr_en;
    logic              rf_rd_en;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rf_rdata;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready, rf_rdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
               rf_wr_en, rf_rd_en, rf_addr, rf_wdata
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready, rf_rdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
               rf_wr_en, rf_rd_en, rf_addr, rf_wdata
    );
endinterface

// File: rtl/regfile_access_master.sv
// Register-file access initiator. Takes one command at a time (read, write,
// XOR read-modify-write), drives single-cycle rf_rd_en / rf_wr_en strobes,
// waits RD_LAT cycles for read data and returns one response per command.
// Optional feature macro: REGACC_RMW_EN. When undefined, op 10 is rejected
// exactly like op 11 and no XOR datapath is built.
module regfile_access_master #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int RD_LAT = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    regfile_access_master_if.master    bus
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_WAIT  = 3'd2,
        WR_ISSUE = 3'd3,
        RESP     = 3'd4
    } state_t;

    // Counter reload so the sample lands RD_LAT cycles after the rd strobe.
    localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);

    state_t            state_reg;
    state_t            state_next;
    logic [2:0]        cnt_reg;
    logic [ADDR_W-1:0] rf_addr_reg;
    logic [DATA_W-1:0] rf_wdata_reg;
    logic [DATA_W-1:0] rsp_rdata_reg;   // also the read holding register
    logic              rsp_err_reg;
    logic              rmw_reg;

    logic op_read;
    logic op_write;
    logic op_rmw;
    logic op_legal;

`ifdef REGACC_RMW_EN
    logic [DATA_W-1:0] mask_reg;
    logic [DATA_W-1:0] rmw_wdata;

    // XOR of the freshly returned register value with the latched mask.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_xor
            assign rmw_wdata[gi] = bus.rf_rdata[gi] ^ mask_reg[gi];
        end
    endgenerate
`endif

    // Decode the operation presented on the command bus.
    always_comb begin
        op_read  = (bus.cmd_op == 2'b00);
        op_write = (bus.cmd_op == 2'b01);
`ifdef REGACC_RMW_EN
        op_rmw   = (bus.cmd_op == 2'b10);
`else
        op_rmw   = 1'b0;
`endif
        op_legal = op_read || op_write || op_rmw;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.cmd_valid) begin
                    if (op_read || op_rmw) begin
                        state_next = RD_ISSUE;
                    end else if (op_write) begin
                        state_next = WR_ISSUE;
                    end else begin
                        state_next = RESP;
                    end
                end
            end
            RD_ISSUE: state_next = RD_WAIT;
            RD_WAIT: begin
                if (cnt_reg == 3'd0) begin
                    state_next = rmw_reg ? WR_ISSUE : RESP;
                end
            end
            WR_ISSUE: state_next = RESP;
            RESP: begin
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Command latching, latency counter, read sampling and write-data forming.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg       <= 3'd0;
            rf_addr_reg   <= '0;
            rf_wdata_reg  <= '0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
`ifdef REGACC_RMW_EN
            rmw_reg       <= 1'b0;
            mask_reg      <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        rsp_err_reg   <= !op_legal;
                        rsp_rdata_reg <= '0;
`ifdef REGACC_RMW_EN
                        rmw_reg       <= op_rmw;
                        mask_reg      <= bus.cmd_wdata;
`endif
                        // Illegal commands leave the rf bus untouched.
                        if (op_legal) begin
                            rf_addr_reg <= bus.cmd_addr;
                        end
                        if (op_write) begin
                            rf_wdata_reg <= bus.cmd_wdata;
                        end
                    end
                end
                RD_ISSUE: begin
                    cnt_reg <= LAT_LOAD;
                end
                RD_WAIT: begin
                    if (cnt_reg == 3'd0) begin
                        rsp_rdata_reg <= bus.rf_rdata;
`ifdef REGACC_RMW_EN
                        if (rmw_reg) begin
                            rf_wdata_reg <= rmw_wdata;
                        end
`endif
                    end else begin
                        cnt_reg <= cnt_reg - 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifndef REGACC_RMW_EN
    assign rmw_reg = 1'b0;
`endif

    assign bus.cmd_ready = (state_reg == IDLE);
    assign bus.rsp_valid = (state_reg == RESP);
    assign bus.rsp_rdata = rsp_rdata_reg;
    assign bus.rsp_err   = rsp_err_reg;
    assign bus.rf_rd_en  = (state_reg == RD_ISSUE);
    assign bus.rf_wr_en  = (state_reg == WR_ISSUE);
    assign bus.rf_addr   = rf_addr_reg;
    assign bus.rf_wdata  = rf_wdata_reg;
endmodule

// File: tb/tb_regfile_access_master.sv
// Directed bench for regfile_access_master: a vector table on an RD_LAT=1
// instance plus hand sequences for backpressure/back-to-back and a reset
// during the read wait of an RD_LAT=4 instance.
module tb_regfile_access_master;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NV = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_access_master_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();
    regfile_access_master_if #(.DATA_W(DW), .ADDR_W(AW)) bus4 ();

    regfile_access_master #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );
    regfile_access_master #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(4)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4)
    );

    int checks = 0;
    int errors = 0;

    // Register-file model for dut1: one-cycle read latency, garbage otherwise.
    logic [DW-1:0] mem1 [0:31];
    logic          pre_en = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;
    int wr_cnt1 = 0;
    int rd_cnt1 = 0;
    int both_cnt1 = 0;
    always @(posedge clk) begin
        if (pre_en) mem1[pre_addr] <= pre_data;
        else if (bus1.rf_wr_en) mem1[bus1.rf_addr] <= bus1.rf_wdata;
        if (bus1.rf_wr_en) wr_cnt1 <= wr_cnt1 + 1;
        if (bus1.rf_rd_en) rd_cnt1 <= rd_cnt1 + 1;
        if (bus1.rf_wr_en && bus1.rf_rd_en) both_cnt1 <= both_cnt1 + 1;
        bus1.rf_rdata <= bus1.rf_rd_en ? mem1[bus1.rf_addr] : 32'hDEAD_BEEF;
    end

    // Register-file model for dut4: four-stage read pipe, value derived from addr.
    logic [DW-1:0] pipe4 [0:3];
    int wr_cnt4 = 0;
    int rd_cnt4 = 0;
    always @(posedge clk) begin
        pipe4[0] <= bus4.rf_rd_en ? (32'h4A00_0000 | 32'(bus4.rf_addr)) : 32'hDEAD_BEEF;
        for (int k = 1; k < 4; k++) pipe4[k] <= pipe4[k-1];
        if (bus4.rf_wr_en) wr_cnt4 <= wr_cnt4 + 1;
        if (bus4.rf_rd_en) rd_cnt4 <= rd_cnt4 + 1;
    end
    assign bus4.rf_rdata = pipe4[3];

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] preload;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_wr;
        int          exp_rd;
        int          exp_lat;
        logic [31:0] exp_mem;
    } vec_t;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic preload1(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    // Issue one command to dut1, measure accept-to-rsp_valid, then handshake.
    task automatic run_cmd1(input logic [1:0] op, input logic [4:0] a, input logic [31:0] wd,
                            output int lat, output logic [31:0] rd, output logic er);
        int w;
        @(negedge clk);
        bus1.cmd_valid = 1'b1; bus1.cmd_op = op; bus1.cmd_addr = a; bus1.cmd_wdata = wd;
        w = 0;
        while (!bus1.cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1 bus1.cmd_valid = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (bus1.rsp_valid) break;
        end
        rd = bus1.rsp_rdata;
        er = bus1.rsp_err;
        bus1.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus1.rsp_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int wr0;
        int rd0;
        int seen;
        logic [31:0] rdata;
        logic err;

        bus1.cmd_valid = 1'b0; bus1.cmd_op = 2'b00; bus1.cmd_addr = '0; bus1.cmd_wdata = '0;
        bus1.rsp_ready = 1'b0;
        bus4.cmd_valid = 1'b0; bus4.cmd_op = 2'b00; bus4.cmd_addr = '0; bus4.cmd_wdata = '0;
        bus4.rsp_ready = 1'b0;

        //            op     addr   wdata         preload       rdata         err  wr rd lat mem
        vecs[0] = '{2'b01, 5'h0F, 32'hA5A5_0001, 32'h0000_0000, 32'h0000_0000, 1'b0, 1, 0, 2, 32'hA5A5_0001};
        vecs[1] = '{2'b00, 5'h1F, 32'h0000_0000, 32'h2003_0821, 32'h2003_0821, 1'b0, 0, 1, 3, 32'h2003_0821};
`ifdef REGACC_RMW_EN
        vecs[2] = '{2'b10, 5'h03, 32'h0000_0F0F, 32'h0000_00FF, 32'h0000_00FF, 1'b0, 1, 1, 4, 32'h0000_0FF0};
        vecs[6] = '{2'b10, 5'h1E, 32'h0F0F_F0F0, 32'hFFFF_0000, 32'hFFFF_0000, 1'b0, 1, 1, 4, 32'hF0F0_F0F0};
`else
        vecs[2] = '{2'b10, 5'h03, 32'h0000_0F0F, 32'h0000_00FF, 32'h0000_0000, 1'b1, 0, 0, 1, 32'h0000_00FF};
        vecs[6] = '{2'b10, 5'h1E, 32'h0F0F_F0F0, 32'hFFFF_0000, 32'h0000_0000, 1'b1, 0, 0, 1, 32'hFFFF_0000};
`endif
        vecs[3] = '{2'b11, 5'h07, 32'h1234_5678, 32'h0000_0055, 32'h0000_0000, 1'b1, 0, 0, 1, 32'h0000_0055};
        vecs[4] = '{2'b01, 5'h00, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1, 0, 2, 32'hFFFF_FFFF};
        vecs[5] = '{2'b00, 5'h0A, 32'h0000_0000, 32'h8000_0001, 32'h8000_0001, 1'b0, 0, 1, 3, 32'h8000_0001};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", 32'(bus1.cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus1.rsp_valid), 32'd0);
        chk("rst_rsp_err",   32'(bus1.rsp_err),   32'd0);
        chk("rst_rsp_rdata", bus1.rsp_rdata,      32'd0);
        chk("rst_rf_wr_en",  32'(bus1.rf_wr_en),  32'd0);
        chk("rst_rf_rd_en",  32'(bus1.rf_rd_en),  32'd0);
        chk("rst_rf_addr",   32'(bus1.rf_addr),   32'd0);
        chk("rst_rf_wdata",  bus1.rf_wdata,       32'd0);
        chk("rst4_cmd_ready", 32'(bus4.cmd_ready), 32'd1);
        chk("rst4_rsp_valid", 32'(bus4.rsp_valid), 32'd0);

        for (int i = 0; i < NV; i++) begin
            preload1(vecs[i].addr, vecs[i].preload);
            wr0 = wr_cnt1;
            rd0 = rd_cnt1;
            run_cmd1(vecs[i].op, vecs[i].addr, vecs[i].wdata, lat, rdata, err);
            @(negedge clk);
            chk("vec_latency", 32'(lat), 32'(vecs[i].exp_lat));
            chk("vec_rsp_rdata", rdata, vecs[i].exp_rdata);
            chk("vec_rsp_err", 32'(err), 32'(vecs[i].exp_err));
            chk("vec_wr_pulses", 32'(wr_cnt1 - wr0), 32'(vecs[i].exp_wr));
            chk("vec_rd_pulses", 32'(rd_cnt1 - rd0), 32'(vecs[i].exp_rd));
            chk("vec_reg_value", mem1[vecs[i].addr], vecs[i].exp_mem);
            chk("vec_idle_ready", 32'(bus1.cmd_ready), 32'd1);
            chk("vec_rsp_drop", 32'(bus1.rsp_valid), 32'd0);
            $display("vec %0d op=%0d addr=%h rdata=%h err=%0d lat=%0d", i, vecs[i].op,
                     vecs[i].addr, rdata, err, lat);
        end

        // Backpressure on a read, with a write pending on the command side.
        @(negedge clk);
        bus1.cmd_valid = 1'b1; bus1.cmd_op = 2'b00; bus1.cmd_addr = 5'h1F; bus1.cmd_wdata = '0;
        @(posedge clk);
        #1 bus1.cmd_valid = 1'b0;
        seen = 0;
        while (!bus1.rsp_valid && seen < 40) begin
            @(negedge clk);
            seen++;
        end
        chk("bp_rsp_arrived", 32'(bus1.rsp_valid), 32'd1);
        bus1.cmd_valid = 1'b1; bus1.cmd_op = 2'b01; bus1.cmd_addr = 5'h02; bus1.cmd_wdata = 32'hCAFE_0002;
        wr0 = wr_cnt1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 32'(bus1.rsp_valid), 32'd1);
            chk("bp_rsp_rdata", bus1.rsp_rdata, 32'h2003_0821);
            chk("bp_cmd_ready", 32'(bus1.cmd_ready), 32'd0);
        end
        chk("bp_no_write", 32'(wr_cnt1 - wr0), 32'd0);
        bus1.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus1.rsp_ready = 1'b0;
        @(negedge clk);
        chk("b2b_cmd_ready", 32'(bus1.cmd_ready), 32'd1);
        chk("b2b_rsp_valid", 32'(bus1.rsp_valid), 32'd0);
        @(posedge clk);
        #1 bus1.cmd_valid = 1'b0;
        @(negedge clk);
        chk("b2b_accepted", 32'(bus1.cmd_ready), 32'd0);
        chk("b2b_wr_en", 32'(bus1.rf_wr_en), 32'd1);
        chk("b2b_rf_addr", 32'(bus1.rf_addr), 32'h02);
        chk("b2b_rf_wdata", bus1.rf_wdata, 32'hCAFE_0002);
        seen = 0;
        while (!bus1.rsp_valid && seen < 40) begin
            @(negedge clk);
            seen++;
        end
        chk("b2b_rsp_err", 32'(bus1.rsp_err), 32'd0);
        chk("b2b_rsp_rdata", bus1.rsp_rdata, 32'd0);
        bus1.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus1.rsp_ready = 1'b0;
        $display("backpressure read 1F then write 02 done");

        // RD_LAT=4 read: sample point five edges after accept.
        @(negedge clk);
        bus4.cmd_valid = 1'b1; bus4.cmd_op = 2'b00; bus4.cmd_addr = 5'h05;
        @(posedge clk);
        #1 bus4.cmd_valid = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (bus4.rsp_valid) break;
        end
        chk("lat4_latency", 32'(lat), 32'd6);
        chk("lat4_rsp_rdata", bus4.rsp_rdata, 32'h4A00_0005);
        bus4.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus4.rsp_ready = 1'b0;
        $display("lat4 read addr=05 rdata=%h lat=%0d", bus4.rsp_rdata, lat);

        // Reset while dut4 waits for read data.
        wr0 = wr_cnt4;
        rd0 = rd_cnt4;
        @(negedge clk);
        bus4.cmd_valid = 1'b1; bus4.cmd_op = 2'b00; bus4.cmd_addr = 5'h09;
        @(posedge clk);
        #1 bus4.cmd_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mrst_cmd_ready", 32'(bus4.cmd_ready), 32'd1);
        chk("mrst_rsp_valid", 32'(bus4.rsp_valid), 32'd0);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus4.rsp_valid || bus4.rf_wr_en || !bus4.cmd_ready) seen++;
        end
        chk("mrst_quiet", 32'(seen), 32'd0);
        chk("mrst_wr_pulses", 32'(wr_cnt4 - wr0), 32'd0);
        chk("mrst_rd_pulses", 32'(rd_cnt4 - rd0), 32'd1);
        $display("reset during RD_WAIT on lat4 instance done");

        chk("strobes_exclusive", 32'(both_cnt1), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
